// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with wait-state timeout.
// Latency: beq 3, R-type/addi/sw 4, lw 5 cycles with mem_ready held high.
// Backpressure: FETCH, MEMRD and MEMWR stall on mem_ready=0; a stall of TIMEOUT cycles faults.
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    IEXEC  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Counter only needs to reach TIMEOUT; a 1-bit stub remains when the timeout is disabled.
  localparam int              WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic            TO_EN     = (TIMEOUT > 0);

  state_t            state, state_next;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              waiting;
  logic              timeout_hit;

  assign state_o     = state;
  assign waiting     = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
  assign wait_inc    = wait_cnt + 1'b1;
  assign timeout_hit = TO_EN && waiting && (wait_inc == TIMEOUT_V);

  // State register plus latched opcode, wait counter, retire counter and sticky fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) op_q <= opcode;
      if (state_next != state)     wait_cnt <= '0;
      else if (waiting && TO_EN)   wait_cnt <= wait_inc;
      if (instr_done) instret <= instret + CNT_W'(1);
      if (state_next == FAULT) fault <= 1'b1;
    end
  end

  // Next-state selection; a wait-state timeout overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXEC;
          OP_I:         state_next = IEXEC;
          OP_BEQ:       state_next = BRANCH;
          default:      state_next = FAULT;
        endcase
      end
      MEMADR: state_next = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_next = MEMWB;
      MEMWB:  state_next = FETCH;
      MEMWR:  if (mem_ready) state_next = FETCH;
      EXEC:   state_next = ALUWB;
      IEXEC:  state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      FAULT:  state_next = FAULT;
      default: state_next = FAULT;
    endcase
    if (timeout_hit) state_next = FAULT;
  end

  // Control decode from state; write enables and retire pulse are suppressed during reset.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    Branch     = 1'b0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b10;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default, TIMEOUT=0 and CNT_W=4 instances share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Each check is an immediate assertion; the run ends with a single summary line.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;

  // default instance
  logic        pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, mem2reg, src_a, br, done, flt;
  logic [1:0]  src_b, alu_op;
  logic [31:0] icnt;
  logic [3:0]  st;

  // TIMEOUT=0 instance
  logic        t0_pc_wr, t0_ir_wr, t0_iord, t0_mem_rd, t0_mem_wr, t0_reg_wr, t0_mem2reg;
  logic        t0_src_a, t0_br, t0_done, t0_flt;
  logic [1:0]  t0_src_b, t0_alu_op;
  logic [31:0] t0_icnt;
  logic [3:0]  t0_st;

  // CNT_W=4 instance
  logic        c4_pc_wr, c4_ir_wr, c4_iord, c4_mem_rd, c4_mem_wr, c4_reg_wr, c4_mem2reg;
  logic        c4_src_a, c4_br, c4_done, c4_flt;
  logic [1:0]  c4_src_b, c4_alu_op;
  logic [3:0]  c4_icnt;
  logic [3:0]  c4_st;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pc_wr), .IRWrite(ir_wr), .IorD(iord), .MemRead(mem_rd), .MemWrite(mem_wr),
    .RegWrite(reg_wr), .MemtoReg(mem2reg), .ALUSrcA(src_a), .ALUSrcB(src_b), .ALUOp(alu_op),
    .Branch(br), .instr_done(done), .instret(icnt), .fault(flt), .state_o(st)
  );

  multicycle_control #(.TIMEOUT(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(t0_pc_wr), .IRWrite(t0_ir_wr), .IorD(t0_iord), .MemRead(t0_mem_rd),
    .MemWrite(t0_mem_wr), .RegWrite(t0_reg_wr), .MemtoReg(t0_mem2reg), .ALUSrcA(t0_src_a),
    .ALUSrcB(t0_src_b), .ALUOp(t0_alu_op), .Branch(t0_br), .instr_done(t0_done),
    .instret(t0_icnt), .fault(t0_flt), .state_o(t0_st)
  );

  multicycle_control #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(c4_pc_wr), .IRWrite(c4_ir_wr), .IorD(c4_iord), .MemRead(c4_mem_rd),
    .MemWrite(c4_mem_wr), .RegWrite(c4_reg_wr), .MemtoReg(c4_mem2reg), .ALUSrcA(c4_src_a),
    .ALUSrcB(c4_src_b), .ALUOp(c4_alu_op), .Branch(c4_br), .instr_done(c4_done),
    .instret(c4_icnt), .fault(c4_flt), .state_o(c4_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b1;
    tick(); tick();
    // reset held: FETCH with mem_ready high, enables forced low
    chk("rst_state", st, 0);
    chk("rst_pcwrite", pc_wr, 0);
    chk("rst_irwrite", ir_wr, 0);
    chk("rst_memread", mem_rd, 0);
    chk("rst_instret", icnt, 0);
    chk("rst_fault", flt, 0);

    // R-type: 0,1,6,8,0
    rst_n = 1'b1; #1;
    chk("r_fetch_state", st, 0);
    chk("r_fetch_pcwrite", pc_wr, 1);
    chk("r_fetch_irwrite", ir_wr, 1);
    chk("r_fetch_memread", mem_rd, 1);
    chk("r_fetch_srcb", src_b, 2'b01);
    tick();
    chk("r_dec_state", st, 1);
    chk("r_dec_srcb", src_b, 2'b10);
    chk("r_dec_pcwrite", pc_wr, 0);
    tick();
    chk("r_exec_state", st, 6);
    chk("r_exec_srca", src_a, 1);
    chk("r_exec_srcb", src_b, 2'b00);
    chk("r_exec_aluop", alu_op, 2'b10);
    chk("r_exec_regwrite", reg_wr, 0);
    tick();
    chk("r_wb_state", st, 8);
    chk("r_wb_regwrite", reg_wr, 1);
    chk("r_wb_memtoreg", mem2reg, 0);
    chk("r_wb_done", done, 1);
    chk("r_wb_instret", icnt, 0);
    tick();
    chk("r_end_state", st, 0);
    chk("r_end_regwrite", reg_wr, 0);
    chk("r_end_instret", icnt, 1);

    // lw with three wait cycles; opcode changed after DECODE must be ignored
    opcode = OP_LW;
    tick();
    chk("lw_dec_state", st, 1);
    tick();
    chk("lw_madr_state", st, 2);
    chk("lw_madr_srca", src_a, 1);
    chk("lw_madr_srcb", src_b, 2'b10);
    opcode = OP_SW; mem_ready = 1'b0;
    tick();
    chk("lw_rd1_state", st, 3);
    chk("lw_rd1_iord", iord, 1);
    chk("lw_rd1_memread", mem_rd, 1);
    chk("lw_rd1_memwrite", mem_wr, 0);
    tick();
    chk("lw_rd2_state", st, 3);
    tick();
    chk("lw_rd3_state", st, 3);
    tick();
    chk("lw_rd4_state", st, 3);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_state", st, 4);
    chk("lw_wb_regwrite", reg_wr, 1);
    chk("lw_wb_memtoreg", mem2reg, 1);
    chk("lw_wb_done", done, 1);
    tick();
    chk("lw_end_state", st, 0);
    chk("lw_end_instret", icnt, 2);

    // sw with one wait cycle in MEMWR
    opcode = OP_SW;
    tick();
    tick();
    chk("sw_madr_state", st, 2);
    mem_ready = 1'b0;
    tick();
    chk("sw_wr_state", st, 5);
    chk("sw_wr_memwrite", mem_wr, 1);
    chk("sw_wr_iord", iord, 1);
    chk("sw_wr_wait_done", done, 0);
    mem_ready = 1'b1; #1;
    chk("sw_wr_done", done, 1);
    tick();
    chk("sw_end_state", st, 0);
    chk("sw_end_instret", icnt, 3);

    // beq
    opcode = OP_BEQ;
    tick();
    tick();
    chk("beq_state", st, 9);
    chk("beq_branch", br, 1);
    chk("beq_aluop", alu_op, 2'b01);
    chk("beq_srca", src_a, 1);
    chk("beq_done", done, 1);
    tick();
    chk("beq_end_state", st, 0);
    chk("beq_end_instret", icnt, 4);
    chk("beq_end_c4_instret", c4_icnt, 4);

    // illegal opcode -> absorbing FAULT
    opcode = OP_BAD;
    tick();
    tick();
    chk("bad_state", st, 10);
    chk("bad_fault", flt, 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      chk("bad_hold_fault", flt, 1);
      chk("bad_hold_state", st, 10);
      chk("bad_hold_we", {27'd0, pc_wr, ir_wr, mem_rd, mem_wr, reg_wr}, 0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("bad_rst_state", st, 0);
    chk("bad_rst_fault", flt, 0);
    chk("bad_rst_instret", icnt, 0);
    rst_n = 1'b1;

    // 17 back-to-back beq: 4-bit counter wraps to 1
    opcode = OP_BEQ; mem_ready = 1'b1;
    repeat (51) tick();
    chk("wrap_state", st, 0);
    chk("wrap_c4_instret", c4_icnt, 1);
    chk("wrap_instret", icnt, 17);

    // FETCH starved: fault after exactly 15 wait cycles; TIMEOUT=0 never faults
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_ready = 1'b0;
    repeat (14) tick();
    chk("to_14_state", st, 0);
    chk("to_14_fault", flt, 0);
    tick();
    chk("to_15_state", st, 10);
    chk("to_15_fault", flt, 1);
    chk("to_15_t0_state", t0_st, 0);
    repeat (20) tick();
    chk("to_t0_state", t0_st, 0);
    chk("to_t0_fault", t0_flt, 0);
    chk("to_t0_memread", t0_mem_rd, 1);

    // reset asserted mid-MEMWR wait
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_SW;
    tick();
    tick();
    tick();
    chk("rw_state", st, 5);
    mem_ready = 1'b0; rst_n = 1'b0; #1;
    chk("rw_memwrite", mem_wr, 0);
    chk("rw_done", done, 0);
    tick();
    chk("rw_end_state", st, 0);
    chk("rw_end_instret", icnt, 0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15: max consecutive wait cycles with mem_ready low before fault; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 opcode  in  7  instr[6:0] from the instruction register.
REQ-006 mem_ready  in  1  memory acknowledge for the current read or write.
REQ-007 PCWrite, IRWrite  out  1 each  PC update enable; instruction register load enable.
REQ-008 IorD  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 MemRead, MemWrite  out  1 each  memory read request; memory write request.
REQ-010 RegWrite, MemtoReg  out  1 each  register file write enable; writeback select (1 = memory data).
REQ-011 ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = rs1.
REQ-012 ALUSrcB  out  2  ALU operand B: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-013 ALUOp  out  2  00 = ADD, 01 = SUB, 10 = R-type funct decode, 11 = I-type funct decode.
REQ-014 Branch  out  1  branch-taken qualifier (combined with ALU zero outside this block).
REQ-015 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-016 instret  out  CNT_W  count of retired instructions.
REQ-017 fault  out  1  sticky error flag.
REQ-018 state_o  out  4  current state encoding, for debug.

Function
REQ-019 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, IEXEC=7, ALUWB=8, BRANCH=9, FAULT=10.
REQ-020 Outputs are Moore, decoded from state; exceptions are PCWrite and IRWrite (REQ-021) and instr_done in MEMWR (REQ-027). Any output not listed for a state is 0.
REQ-021 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
- PCWrite=1 and IRWrite=1 only in the cycle where mem_ready=1; the FSM then goes to DECODE.
- Otherwise the FSM stays in FETCH.
REQ-022 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00. Latches opcode into op_q. Next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXEC
- 0010011 -> IEXEC
- 1100011 -> BRANCH
- any other value -> FAULT
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state by op_q: lw -> MEMRD, sw -> MEMWR.
REQ-024 MEMRD: IorD=1, MemRead=1. Stays until mem_ready=1, then goes to MEMWB.
REQ-025 MEMWB: RegWrite=1, MemtoReg=1, instr_done=1 -> FETCH.
REQ-026 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
REQ-027 MEMWR: IorD=1, MemWrite=1. Stays until mem_ready=1; instr_done=1 in that cycle, then goes to FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, instr_done=1 -> FETCH.
REQ-029 Latency with mem_ready held at 1: beq 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles.
REQ-030 Wait counter:
- Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
- Clears on every state change.
- When it reaches TIMEOUT (TIMEOUT>0), the next state is FAULT, overriding any other transition.
REQ-031 FAULT: all control outputs 0, fault=1. FAULT is absorbing until reset.
REQ-032 instret increments by 1 on each instr_done cycle. It wraps from 2^CNT_W-1 to 0.
REQ-033 op_q is the only decode source after DECODE; opcode changes after DECODE have no effect.

Reset
REQ-034 When rst_n=0 at a rising edge, all of the following are set:
- state = FETCH
- op_q = 0
- wait counter = 0
- instret = 0
- fault = 0
REQ-035 While rst_n=0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite and instr_done are forced to 0.
REQ-036 Reset in any state, including FAULT or mid-wait, aborts the instruction with no further write-enable pulses.

Verification
REQ-037 mem_ready=1 and opcode=0110011 after reset -> states 0,1,6,8,0; RegWrite=1 only in state 8; instret=1 after 4 cycles.
REQ-038 lw (0000011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; then MEMWB with MemtoReg=1; total 8 cycles.
REQ-039 opcode=1111111 in DECODE -> FAULT next cycle; fault=1 held 20 cycles; no write enables; rst_n low for 1 cycle -> state 0, fault=0.
REQ-040 TIMEOUT=15, mem_ready=0 in FETCH -> FAULT exactly after 15 wait cycles. TIMEOUT=0 -> stays in FETCH indefinitely.
REQ-041 CNT_W=4, 17 consecutive beq instructions -> instret=1 after wrap.
REQ-042 rst_n asserted in MEMWR with mem_ready=0 -> MemWrite=0 in that cycle; state 0 next cycle; instret unchanged = 0.
